// File: rtl/clock_div_prog.sv
// clock_div_prog: runtime-programmable divided level and period tick.
// The output period N is loaded through a one-cycle strobe and only takes
// effect at a period boundary, so neither clk_sys nor tick ever produce a
// runt or stretched period.
// Optional build macro CLKDIV_PERIOD_CNT_EN adds the period_cnt output, a
// free-running count of emitted ticks.
module clock_div_prog #(
    parameter int DIV_WIDTH   = 27,
    parameter int DEFAULT_DIV = 100000000,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic                 div_load,
    output logic                 clk_sys,
    output logic                 tick,
    output logic                 div_pending,
    output logic                 div_err
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] period_cnt
`endif
);

    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] CNT_RST = DIV_WIDTH'(DEFAULT_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO     = DIV_WIDTH'(2);

    // Reject parameter sets the counter cannot represent.
    if (DIV_WIDTH < 2 || DIV_WIDTH > 62) begin : g_bad_div_width
        $error("clock_div_prog: DIV_WIDTH out of range");
    end
    if (DEFAULT_DIV < 2 || longint'(DEFAULT_DIV) > ((64'sd1 <<< DIV_WIDTH) - 64'sd1)) begin : g_bad_default
        $error("clock_div_prog: DEFAULT_DIV does not fit DIV_WIDTH or is below 2");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("clock_div_prog: CNT_WIDTH must be at least 1");
    end

    logic [DIV_WIDTH-1:0] cnt;       // position inside the current period
    logic [DIV_WIDTH-1:0] div_act;   // period currently being generated
    logic [DIV_WIDTH-1:0] div_next;  // period waiting for the next boundary
    logic [DIV_WIDTH-1:0] cnt_inc;
    logic [DIV_WIDTH-1:0] last_cnt;
    logic [DIV_WIDTH-1:0] high_len;
    logic                 wrap;
    logic                 step;
    logic                 load_ok;
    logic                 load_bad;

    // Period decode: wrap on the last count, high phase is ceil(N/2) long.
    always_comb begin
        cnt_inc  = cnt + ONE;
        last_cnt = div_act - ONE;
        high_len = div_act - (div_act >> 1);
        wrap     = (cnt == last_cnt);
        step     = en && wrap;
        load_ok  = div_load && (div_val >= TWO);
        load_bad = div_load && (div_val < TWO);
    end

    // Period counter, divided level and boundary tick; all frozen while en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= CNT_RST;
            clk_sys <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= step;
            if (en) begin
                if (wrap) begin
                    cnt     <= '0;
                    clk_sys <= 1'b1;
                end else begin
                    cnt     <= cnt_inc;
                    clk_sys <= (cnt_inc < high_len);
                end
            end
        end
    end

    // Divisor handshake: a boundary consumes the old pending value before a
    // same-cycle load refills it, so the newer load waits one more period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_act     <= DIV_RST;
            div_next    <= '0;
            div_pending <= 1'b0;
        end else begin
            if (step && div_pending) begin
                div_act     <= div_next;
                div_pending <= 1'b0;
            end
            if (load_ok) begin
                div_next    <= div_val;
                div_pending <= 1'b1;
            end
        end
    end

    // Sticky flag reflecting whether the most recent load was rejected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_err <= 1'b0;
        end else if (load_bad) begin
            div_err <= 1'b1;
        end else if (load_ok) begin
            div_err <= 1'b0;
        end
    end

`ifdef CLKDIV_PERIOD_CNT_EN
    // Counts ticks; advances on the same edge that raises tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (step) begin
            period_cnt <= period_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_clock_div_prog.sv
// Scoreboard bench for clock_div_prog. The reference model describes each
// output period as a queue of levels (ceil(N/2) highs then floor(N/2) lows);
// a new period starts when that queue is exhausted.
module tb_clock_div_prog;

    localparam int DW  = 8;
    localparam int DEF = 6;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] div_val;
    logic          div_load;
    logic          clk_sys;
    logic          tick;
    logic          div_pending;
    logic          div_err;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [CW-1:0] period_cnt;
`endif

    clock_div_prog #(.DIV_WIDTH(DW), .DEFAULT_DIV(DEF), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .div_val     (div_val),
        .div_load    (div_load),
        .clk_sys     (clk_sys),
        .tick        (tick),
        .div_pending (div_pending),
        .div_err     (div_err)
`ifdef CLKDIV_PERIOD_CNT_EN
        ,
        .period_cnt  (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          clk_sys;
        logic          tick;
        logic          pend;
        logic          err;
        logic [CW-1:0] pcnt;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    bit            wave[$];
    int            n_m;
    int            pend_m;
    bit            pend_v;
    bit            err_m;
    bit            clk_m;
    bit            tick_m;
    logic [CW-1:0] pcnt_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        wave.delete();
        n_m    = DEF;
        pend_m = 0;
        pend_v = 0;
        err_m  = 0;
        clk_m  = 0;
        tick_m = 0;
        pcnt_m = '0;
    endtask

    task automatic model_step(input bit e, input bit ld, input logic [DW-1:0] v);
        exp_t x;
        tick_m = 0;
        if (e) begin
            if (wave.size() == 0) begin
                if (pend_v) begin
                    n_m    = pend_m;
                    pend_v = 0;
                end
                for (int i = 0; i < n_m; i++) wave.push_back(i < (n_m - n_m / 2));
                tick_m = 1;
                pcnt_m = pcnt_m + 1'b1;
            end
            clk_m = wave.pop_front();
        end
        if (ld) begin
            if (int'(v) >= 2) begin
                pend_m = int'(v);
                pend_v = 1;
                err_m  = 0;
            end else begin
                err_m = 1;
            end
        end
        x.cyc     = cyc + 1;
        x.clk_sys = clk_m;
        x.tick    = tick_m;
        x.pend    = pend_v;
        x.err     = err_m;
        x.pcnt    = pcnt_m;
        q.push_back(x);
    endtask

    // Called at posedge+1: apply inputs for the coming edge, record expectation.
    task automatic drive(input bit e, input bit ld, input logic [DW-1:0] v);
        en       = e;
        div_load = ld;
        div_val  = v;
        model_step(e, ld, v);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst      = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        #1;
        check({tag, "_clk_sys"}, clk_sys, 0);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_pending"}, div_pending, 0);
        check({tag, "_err"}, div_err, 0);
`ifdef CLKDIV_PERIOD_CNT_EN
        check({tag, "_period_cnt"}, period_cnt, 0);
`endif
        q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare the DUT against the expectation recorded for this cycle.
    always @(negedge clk) begin
        if (!rst && q.size() > 0 && q[0].cyc == cyc) begin
            exp_t x;
            x = q.pop_front();
            check("clk_sys", clk_sys, x.clk_sys);
            check("tick", tick, x.tick);
            check("div_pending", div_pending, x.pend);
            check("div_err", div_err, x.err);
`ifdef CLKDIV_PERIOD_CNT_EN
            check("period_cnt", period_cnt, x.pcnt);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_clk_sys", clk_sys, 0);
        check("rst_tick", tick, 0);
        check("rst_pending", div_pending, 0);
        check("rst_err", div_err, 0);
        rst = 1'b0;

        // default period 6
        repeat (14) drive(1, 0, 0);

        // load 5 mid-period, applied at the next boundary
        async_reset("rst2");
        repeat (3) drive(1, 0, 0);
        drive(1, 1, 5);
        repeat (15) drive(1, 0, 0);

        // illegal loads, then a legal one
        async_reset("rst3");
        drive(1, 1, 1);
        drive(1, 1, 0);
        repeat (8) drive(1, 0, 0);
        drive(1, 1, 4);
        repeat (14) drive(1, 0, 0);

        // last load wins; a load on the wrap cycle waits one more period
        drive(1, 1, 8);
        drive(1, 1, 10);
        repeat (wave.size()) drive(1, 0, 0);
        drive(1, 1, 3);
        repeat (25) drive(1, 0, 0);

        // freeze during the high phase
        for (int i = 0; i < 40 && !tick_m; i++) drive(1, 0, 0);
        repeat (4) drive(0, 0, 0);
        repeat (20) drive(1, 0, 0);

        // asynchronous reset while clk_sys is high
        for (int i = 0; i < 40 && !tick_m; i++) drive(1, 0, 0);
        drive(1, 1, 7);
        async_reset("rst_mid");
        repeat (10) drive(1, 0, 0);

        // randomized enables and loads, including illegal values
        for (int i = 0; i < 1500; i++) begin
            bit            e;
            bit            ld;
            logic [DW-1:0] v;
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 11) == 0);
            v  = DW'($urandom_range(0, 14));
            drive(e, ld, v);
        end
        drive(1, 0, 0);

        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
